instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 19 +
 rtl/instr_sequencer_skid.sv | 55 +++++
 rtl/instr_sequencer.sv | 125 ++++++++++++
 tb/tb_instr_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared state encoding and widths for the instruction sequencer.
// Supplies a 32-bit default for `BLOCK_INSTR_WIDTH when the block header has not defined it.
`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif

package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

  localparam int INSTR_SEQ_INSTR_W = `BLOCK_INSTR_WIDTH;
  localparam int INSTR_SEQ_STATE_W = 2;

endpackage

// File: rtl/instr_sequencer_skid.sv
// One-entry skid buffer between the instruction RAM read port and the decoder.
// RAM data passes straight through and is parked here when the decoder stalls.
module instr_skid_reg #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic              out_rdy_i,
  output logic              out_vld_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [PC_W-1:0]   out_pc_o,
  output logic              full_d_o
);

  logic              skid_vld_q;
  logic              skid_vld_d;
  logic              load;
  logic [DATA_W-1:0] skid_data_q;
  logic [PC_W-1:0]   skid_pc_q;

  // A parked word always goes out before the word arriving from the RAM.
  assign skid_vld_d = skid_vld_q ? (in_vld_i | ~out_rdy_i) : (in_vld_i & ~out_rdy_i);
  assign load       = in_vld_i & skid_vld_d;
  assign full_d_o   = skid_vld_d;
  assign out_vld_o  = skid_vld_q | in_vld_i;

  always_comb begin
    out_data_o = '0;
    out_pc_o   = '0;
    if (skid_vld_q) begin
      out_data_o = skid_data_q;
      out_pc_o   = skid_pc_q;
    end else if (in_vld_i) begin
      out_data_o = in_data_i;
      out_pc_o   = in_pc_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) skid_vld_q <= 1'b0;
    else       skid_vld_q <= skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      skid_data_q <= in_data_i;
      skid_pc_q   <= in_pc_i;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Runs one pass over the instruction store per sample_tick, issuing words to the decoder.
// Define INSTR_SEQ_OVERRUN_EN to add the sticky overrun flag for ticks arriving mid-pass.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter  int n_instrs = 64,
  localparam int pc_width = $clog2(n_instrs)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic [pc_width:0]             instr_count,
  output logic [pc_width-1:0]           instr_rd_addr,
  input  logic [`BLOCK_INSTR_WIDTH-1:0] instr_rd_data,
  output logic [`BLOCK_INSTR_WIDTH-1:0] instr_out,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [pc_width-1:0]           pc_out,
  output logic                          busy,
  output logic                          done
`ifdef INSTR_SEQ_OVERRUN_EN
  ,
  output logic                          overrun
`endif
);

  localparam logic [pc_width:0] CNT_MAX = (pc_width+1)'(n_instrs);

  seq_state_t          state_q;
  logic                busy_q;
  logic                done_q;
  logic                pend_q;
  logic [pc_width-1:0] rd_addr_q;
  logic [pc_width-1:0] last_q;
  logic [pc_width-1:0] pend_pc_q;
  logic [pc_width:0]   cnt_clamped;
  logic                skid_full_d;
  logic                issue;
  logic                accept;
  logic                last_xfer;

  assign cnt_clamped = (instr_count > CNT_MAX) ? CNT_MAX : instr_count;
  assign accept      = instr_valid & instr_ready;
  // Only read when the word returning next cycle is guaranteed a place to land.
  assign issue       = (state_q == FETCH) & ~skid_full_d;
  assign last_xfer   = (state_q == ISSUE) & accept & ~skid_full_d;

  assign instr_rd_addr = rd_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;

  instr_skid_reg #(
    .DATA_W (`BLOCK_INSTR_WIDTH),
    .PC_W   (pc_width)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_vld_i   (pend_q),
    .in_data_i  (instr_rd_data),
    .in_pc_i    (pend_pc_q),
    .out_rdy_i  (instr_ready),
    .out_vld_o  (instr_valid),
    .out_data_o (instr_out),
    .out_pc_o   (pc_out),
    .full_d_o   (skid_full_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
      rd_addr_q <= '0;
      last_q    <= '0;
      pend_pc_q <= '0;
    end else begin
      done_q <= 1'b0;
      pend_q <= issue;
      if (issue) pend_pc_q <= rd_addr_q;
      case (state_q)
        IDLE, FINISH: begin
          rd_addr_q <= '0;
          if (!sample_tick) begin
            state_q <= IDLE;
          end else if (cnt_clamped == '0) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            last_q  <= pc_width'(cnt_clamped - 1'b1);
          end
        end
        FETCH: begin
          if (issue) begin
            if (rd_addr_q == last_q) state_q   <= ISSUE;
            else                     rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        ISSUE: begin
          if (last_xfer) begin
            state_q   <= FINISH;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            rd_addr_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef INSTR_SEQ_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     overrun_q <= 1'b0;
    else if (sample_tick && busy_q) overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a one-cycle-latency instruction RAM model.
`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif

module tb_instr_sequencer;

  localparam int N  = 64;
  localparam int PW = 6;
  localparam int W  = `BLOCK_INSTR_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic [PW:0]   instr_count;
  logic [PW-1:0] instr_rd_addr;
  logic [W-1:0]  instr_rd_data;
  logic [W-1:0]  instr_out;
  logic          instr_valid;
  logic          instr_ready;
  logic [PW-1:0] pc_out;
  logic          busy;
  logic          done;
`ifdef INSTR_SEQ_OVERRUN_EN
  logic          overrun;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mem [N];

  instr_sequencer #(.n_instrs(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .instr_count   (instr_count),
    .instr_rd_addr (instr_rd_addr),
    .instr_rd_data (instr_rd_data),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc_out        (pc_out),
    .busy          (busy),
    .done          (done)
`ifdef INSTR_SEQ_OVERRUN_EN
    ,
    .overrun       (overrun)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_rd_data <= mem[instr_rd_addr];

  function automatic logic [W-1:0] word_of(input int idx);
    return W'(32'hC0DE_0000 + 32'(idx) * 32'h0000_0101);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_tick = 1'b0; instr_ready = 1'b1; instr_count = '0;
    next_cycle();
    #1;
    checks++;
    if ({instr_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got valid/busy/done=%b, want 000", {instr_valid, busy, done});
    end
    checks++;
    if (pc_out !== '0 || instr_rd_addr !== '0 || instr_out !== '0) begin
      errors++; $display("FAIL reset_data: got pc=%0d addr=%0d out=%h, want 0 0 0", pc_out, instr_rd_addr, instr_out);
    end
`ifdef INSTR_SEQ_OVERRUN_EN
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, want 0", overrun); end
`endif
    next_cycle();
    reset = 1'b0;
    repeat (2) next_cycle();
  endtask

  task automatic test_basic();
    logic exp_v, exp_busy, exp_done;
    logic [PW-1:0] exp_pc;
    instr_count = 7'd4; instr_ready = 1'b1; sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      #1;
      exp_v    = (k >= 2 && k <= 5);
      exp_pc   = exp_v ? PW'(k - 2) : '0;
      exp_busy = (k >= 1 && k <= 5);
      exp_done = (k == 6);
      checks++;
      if (instr_valid !== exp_v || pc_out !== exp_pc) begin
        errors++; $display("FAIL basic_valid_pc k=%0d: got v=%b pc=%0d, want v=%b pc=%0d", k, instr_valid, pc_out, exp_v, exp_pc);
      end
      checks++;
      if (instr_out !== (exp_v ? word_of(int'(exp_pc)) : '0)) begin
        errors++; $display("FAIL basic_word k=%0d: got %h, want %h", k, instr_out, exp_v ? word_of(int'(exp_pc)) : '0);
      end
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        errors++; $display("FAIL basic_busy_done k=%0d: got busy=%b done=%b, want %b %b", k, busy, done, exp_busy, exp_done);
      end
      if (k == 1) begin
        checks++;
        if (instr_rd_addr !== '0) begin errors++; $display("FAIL basic_first_addr: got %0d, want 0", instr_rd_addr); end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    int pc_tab [11] = '{0, 0, 0, 1, 1, 1, 1, 2, 3, 0, 0};
    int xfers = 0;
    int max_addr = 0;
    logic exp_v;
    instr_count = 7'd4; instr_ready = 1'b1; sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      instr_ready = !(k >= 3 && k <= 5);
      #1;
      exp_v = (k >= 2 && k <= 8);
      if (int'(instr_rd_addr) > max_addr) max_addr = int'(instr_rd_addr);
      checks++;
      if (instr_valid !== exp_v || pc_out !== PW'(pc_tab[k]) || done !== (k == 9)) begin
        errors++; $display("FAIL stall_seq k=%0d: got v=%b pc=%0d done=%b, want v=%b pc=%0d done=%b",
                           k, instr_valid, pc_out, done, exp_v, pc_tab[k], (k == 9));
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if (instr_out !== word_of(xfers) || pc_out !== PW'(xfers)) begin
          errors++; $display("FAIL stall_xfer #%0d: got word=%h pc=%0d, want word=%h pc=%0d", xfers, instr_out, pc_out, word_of(xfers), xfers);
        end
        xfers++;
      end
      next_cycle();
    end
    instr_ready = 1'b1;
    checks++;
    if (xfers != 4) begin errors++; $display("FAIL stall_count: got %0d transfers, want 4", xfers); end
    checks++;
    if (max_addr != 3) begin errors++; $display("FAIL stall_max_addr: got %0d, want 3", max_addr); end
  endtask

  task automatic test_zero_count();
    int seen_valid = 0;
    instr_count = 7'd0; instr_ready = 1'b1; sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      if (instr_valid) seen_valid++;
      checks++;
      if (done !== (k == 1) || busy !== 1'b0) begin
        errors++; $display("FAIL zero_done k=%0d: got done=%b busy=%b, want done=%b busy=0", k, done, busy, (k == 1));
      end
      next_cycle();
    end
    checks++;
    if (seen_valid != 0) begin errors++; $display("FAIL zero_valid: got %0d valid cycles, want 0", seen_valid); end
  endtask

  task automatic test_back_to_back();
    int pc_tab [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 2, 0};
    logic exp_v, exp_busy, exp_done;
    instr_count = 7'd2; instr_ready = 1'b1; sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      sample_tick = (k == 4);
      if (k == 4) instr_count = 7'd3;
      #1;
      exp_v    = (k == 2 || k == 3 || (k >= 6 && k <= 8));
      exp_busy = ((k >= 1 && k <= 3) || (k >= 5 && k <= 8));
      exp_done = (k == 4 || k == 9);
      checks++;
      if (instr_valid !== exp_v || pc_out !== PW'(pc_tab[k]) || busy !== exp_busy || done !== exp_done) begin
        errors++; $display("FAIL b2b k=%0d: got v=%b pc=%0d busy=%b done=%b, want %b %0d %b %b",
                           k, instr_valid, pc_out, busy, done, exp_v, pc_tab[k], exp_busy, exp_done);
      end
      next_cycle();
    end
    sample_tick = 1'b0;
  endtask

  task automatic test_clamp();
    int xfers = 0;
    int max_addr = 0;
    int cyc = 0;
    logic seen_done = 1'b0;
    instr_count = 7'd100; instr_ready = 1'b1; sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    instr_count = 7'd3;
    while (!seen_done && cyc < 300) begin
      instr_ready = (cyc % 4 != 1);
      #1;
      if (int'(instr_rd_addr) > max_addr) max_addr = int'(instr_rd_addr);
      if (instr_valid && instr_ready) begin
        checks++;
        if (instr_out !== word_of(xfers) || pc_out !== PW'(xfers)) begin
          errors++; $display("FAIL clamp_xfer #%0d: got word=%h pc=%0d, want word=%h pc=%0d", xfers, instr_out, pc_out, word_of(xfers), xfers % N);
        end
        xfers++;
      end
      seen_done = done;
      cyc++;
      next_cycle();
    end
    instr_ready = 1'b1;
    checks++;
    if (!seen_done) begin errors++; $display("FAIL clamp_timeout: got no done in %0d cycles, want done", cyc); end
    checks++;
    if (xfers != 64) begin errors++; $display("FAIL clamp_count: got %0d transfers, want 64", xfers); end
    checks++;
    if (max_addr != 63) begin errors++; $display("FAIL clamp_max_addr: got %0d, want 63", max_addr); end
    repeat (2) next_cycle();
  endtask

  task automatic test_overrun();
    int xfers = 0;
    logic exp_v;
`ifdef INSTR_SEQ_OVERRUN_EN
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b, want 0", overrun); end
`endif
    instr_count = 7'd4; instr_ready = 1'b1; sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      sample_tick = (k == 3);
      if (k == 3) instr_count = 7'd1;
      #1;
      exp_v = (k >= 2 && k <= 5);
      checks++;
      if (instr_valid !== exp_v || pc_out !== (exp_v ? PW'(k - 2) : '0) || done !== (k == 6)) begin
        errors++; $display("FAIL overrun_pass k=%0d: got v=%b pc=%0d done=%b, want v=%b pc=%0d done=%b",
                           k, instr_valid, pc_out, done, exp_v, exp_v ? k - 2 : 0, (k == 6));
      end
      if (instr_valid && instr_ready) xfers++;
      next_cycle();
    end
    sample_tick = 1'b0;
    checks++;
    if (xfers != 4) begin errors++; $display("FAIL overrun_count: got %0d transfers, want 4", xfers); end
`ifdef INSTR_SEQ_OVERRUN_EN
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b, want 1", overrun); end
`endif
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    instr_count = 7'd8; instr_ready = 1'b1; sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    repeat (3) next_cycle();
    #1;
    checks++;
    if (pc_out !== 6'd2 || instr_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got pc=%0d v=%b, want pc=2 v=1", pc_out, instr_valid);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({instr_valid, busy, done} !== 3'b000 || pc_out !== '0 || instr_rd_addr !== '0 || instr_out !== '0) begin
      errors++; $display("FAIL midrst_async: got v=%b busy=%b done=%b pc=%0d addr=%0d out=%h, want all 0",
                         instr_valid, busy, done, pc_out, instr_rd_addr, instr_out);
    end
`ifdef INSTR_SEQ_OVERRUN_EN
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b, want 0", overrun); end
`endif
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (done || instr_valid || busy) bad++;
      next_cycle();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles, want 0", bad); end
    instr_count = 7'd3; sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++;
      if (instr_valid !== (k >= 2 && k <= 4) || pc_out !== ((k >= 2 && k <= 4) ? PW'(k - 2) : '0) || done !== (k == 5)) begin
        errors++; $display("FAIL midrst_restart k=%0d: got v=%b pc=%0d done=%b, want v=%b pc=%0d done=%b",
                           k, instr_valid, pc_out, done, (k >= 2 && k <= 4), (k >= 2 && k <= 4) ? k - 2 : 0, (k == 5));
      end
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = word_of(i);
    test_reset();
    test_basic();
    next_cycle();
    test_stall();
    next_cycle();
    test_zero_count();
    test_back_to_back();
    next_cycle();
    test_clamp();
    test_overrun();
    next_cycle();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
